// File: rtl/jtframe_rom_arb_pkg.sv
// Shared types for the ROM arbiter: FSM states, slot limit and
// the helper that unpacks the per-slot SDRAM base offsets.
package jtframe_rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int MAX_SLOTS = 8;
  localparam int MAX_SDW   = 64;
  localparam int OFF_W     = MAX_SLOTS * MAX_SDW;

  // Returns the offset field of slot idx in its low bits; the caller
  // truncates to its own address width, dropping neighbouring fields.
  function automatic logic [MAX_SDW-1:0] slot_base(
    input logic [OFF_W-1:0] offs,
    input int               sdw,
    input int               idx
  );
    logic [OFF_W-1:0] sh;
    sh = offs >> (idx * sdw);
    return sh[MAX_SDW-1:0];
  endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or
// after ptr, wrapping. Ports: eligible, ptr in; valid, winner out.
module jtframe_rr_pick #(
  parameter int SLOTS = 4,
  parameter int PW    = $clog2(SLOTS)
) (
  input  logic [SLOTS-1:0] eligible,
  input  logic [PW-1:0]    ptr,
  output logic             valid,
  output logic [PW-1:0]    winner
);

  int idx;

  // Scan from the far end back to ptr so the closest slot wins last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % SLOTS;
      if (eligible[idx]) begin
        valid  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/jtframe_rom_arb.sv
// Round-robin arbiter sharing one SDRAM read port among ROM slots.
// Ports: slot_req/addr/ok + data_out to slots; sdram_* to controller.
module jtframe_rom_arb
  import jtframe_rom_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int SDW   = 22,
  parameter logic [SLOTS*SDW-1:0] SLOT_OFFSET = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SLOTS-1:0]    slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [31:0]         data_out,
  output logic                sdram_req,
  output logic [SDW-1:0]      sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [31:0]         data_read
);

  localparam int PW = $clog2(SLOTS);
  localparam logic [OFF_W-1:0] OFFS = OFF_W'(SLOT_OFFSET);

  arb_state_t       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    grant;
  logic [SLOTS-1:0] blackout;

  logic [SLOTS-1:0] eligible;
  logic             valid;
  logic [PW-1:0]    win;
  logic [AW-1:0]    raddr;
  logic [SDW-1:0]   base;
  logic [SDW-1:0]   next_addr;
  logic [SLOTS-1:0] grant_oh;
  logic             done;

  // The slot served last cycle may still hold req while it sees ok.
  assign eligible = slot_req & ~blackout;

  jtframe_rr_pick #(
    .SLOTS (SLOTS),
    .PW    (PW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .valid    (valid),
    .winner   (win)
  );

  always_comb begin
    raddr     = slot_addr[int'(win)*AW +: AW];
    base      = SDW'(slot_base(OFFS, SDW, int'(win)));
    next_addr = base + SDW'(raddr);
  end

  assign grant_oh = SLOTS'(1) << grant;

  // Data can land together with the ack, skipping WAIT entirely.
  assign done = data_rdy &&
    ((state == WAIT) || (state == ISSUE && sdram_ack));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      grant      <= '0;
      blackout   <= '0;
      slot_ok    <= '0;
      data_out   <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      slot_ok  <= '0;
      blackout <= '0;
      unique case (state)
        IDLE: begin
          if (valid) begin
            grant      <= win;
            sdram_addr <= next_addr;
            sdram_req  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
        end
        default: state <= IDLE;
      endcase
      if (done) begin
        data_out <= data_read;
        slot_ok  <= grant_oh;
        blackout <= grant_oh;
        ptr      <= (grant == PW'(SLOTS - 1)) ? '0 : grant + PW'(1);
        state    <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Directed self-checking bench for jtframe_rom_arb (4 slots).
// Expected values are hand-computed from offsets and addresses.
module tb_jtframe_rom_arb;

  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int SDW   = 22;
  localparam logic [SLOTS*SDW-1:0] OFFS =
    {22'h3FFFF0, 22'h100000, 22'h000100, 22'h000000};

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [SLOTS-1:0]    slot_req = '0;
  logic [SLOTS*AW-1:0] slot_addr = '0;
  logic [SLOTS-1:0]    slot_ok;
  logic [31:0]         data_out;
  logic                sdram_req;
  logic [SDW-1:0]      sdram_addr;
  logic                sdram_ack = 1'b0;
  logic                data_rdy = 1'b0;
  logic [31:0]         data_read = '0;

  int n_checks = 0;
  int n_fail   = 0;

  jtframe_rom_arb #(
    .SLOTS       (SLOTS),
    .AW          (AW),
    .SDW         (SDW),
    .SLOT_OFFSET (OFFS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_req   (slot_req),
    .slot_addr  (slot_addr),
    .slot_ok    (slot_ok),
    .data_out   (data_out),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .data_read  (data_read)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    slot_req  = '0;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    tick();
    check("rst_req", 32'(sdram_req), 0);
    check("rst_addr", 32'(sdram_addr), 0);
    check("rst_ok", 32'(slot_ok), 0);
    check("rst_data", data_out, 0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_addr(input int s, input logic [AW-1:0] a);
    slot_addr[s*AW +: AW] = a;
  endtask

  // Serve one read: wait for req, ack one cycle later, deliver data.
  task automatic xact(input logic [SDW-1:0] ea,
                      input logic [3:0] eok,
                      input logic [31:0] d,
                      input bit same);
    int n;
    n = 0;
    while (!sdram_req && n < 20) begin
      tick();
      n++;
    end
    check("req_up", 32'(sdram_req), 1);
    check("addr", 32'(sdram_addr), 32'(ea));
    check("ok_idle", 32'(slot_ok), 0);
    tick();
    check("req_hold", 32'(sdram_req), 1);
    sdram_ack = 1'b1;
    if (same) begin
      data_rdy  = 1'b1;
      data_read = d;
    end
    tick();
    sdram_ack = 1'b0;
    if (!same) begin
      check("req_drop", 32'(sdram_req), 0);
      check("ok_wait", 32'(slot_ok), 0);
      tick();
      tick();
      data_rdy  = 1'b1;
      data_read = d;
      tick();
    end
    data_rdy  = 1'b0;
    data_read = 32'h0BAD0BAD;
    check("ok", 32'(slot_ok), 32'(eok));
    check("data", data_out, d);
  endtask

  logic [SDW-1:0] fair_addr [4];

  initial begin
    set_addr(0, 22'h000011);
    set_addr(1, 22'h000022);
    set_addr(2, 22'h001234);
    set_addr(3, 22'h000020);
    fair_addr[0] = 22'h000011;
    fair_addr[1] = 22'h000122;
    fair_addr[2] = 22'h101234;
    fair_addr[3] = 22'h000010;

    // Nothing requested: stray ack/data_rdy in IDLE are ignored.
    reset_dut();
    sdram_ack = 1'b1;
    data_rdy  = 1'b1;
    data_read = 32'h12345678;
    tick();
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    tick();
    check("idle_req", 32'(sdram_req), 0);
    check("idle_ok", 32'(slot_ok), 0);
    check("idle_data", data_out, 0);

    // Single request from slot 2 with slow controller.
    slot_req = 4'b0100;
    tick();
    check("t1_req", 32'(sdram_req), 1);
    check("t1_addr", 32'(sdram_addr), 32'h101234);
    set_addr(2, 22'h003333);
    tick();
    tick();
    check("t1_hold", 32'(sdram_addr), 32'h101234);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("t1_drop", 32'(sdram_req), 0);
    repeat (4) tick();
    check("t1_nook", 32'(slot_ok), 0);
    data_rdy  = 1'b1;
    data_read = 32'hDEADBEEF;
    tick();
    data_rdy = 1'b0;
    slot_req = '0;
    check("t1_ok", 32'(slot_ok), 32'b0100);
    check("t1_data", data_out, 32'hDEADBEEF);
    tick();
    check("t1_okclr", 32'(slot_ok), 0);
    check("t1_keep", data_out, 32'hDEADBEEF);
    set_addr(2, 22'h001234);

    // Fairness: all slots requesting continuously.
    reset_dut();
    slot_req = 4'b1111;
    for (int k = 0; k < 6; k++)
      xact(fair_addr[k % 4], 4'(1 << (k % 4)), 32'h1000_0000 + k, 1'b0);
    slot_req = '0;
    tick();

    // Blackout: slot 1 holds req one cycle past its ok.
    reset_dut();
    slot_req = 4'b0010;
    xact(22'h000122, 4'b0010, 32'hA1A1A1A1, 1'b0);
    tick();
    slot_req = '0;
    check("bo_none", 32'(sdram_req), 0);
    tick();
    check("bo_none2", 32'(sdram_req), 0);

    // Blackout with slot 3 also waiting: slot 3 goes next.
    slot_req = 4'b0010;
    xact(22'h000122, 4'b0010, 32'hB2B2B2B2, 1'b0);
    slot_req = 4'b1010;
    tick();
    slot_req = 4'b1000;
    check("bo_req3", 32'(sdram_req), 1);
    check("bo_addr3", 32'(sdram_addr), 32'h000010);
    xact(22'h000010, 4'b1000, 32'hC3C3C3C3, 1'b0);
    slot_req = '0;
    tick();

    // Ack and data in the same cycle.
    reset_dut();
    slot_req = 4'b0001;
    xact(22'h000011, 4'b0001, 32'h55AA55AA, 1'b1);
    slot_req = '0;
    tick();
    check("same_okclr", 32'(slot_ok), 0);
    check("same_idle", 32'(sdram_req), 0);

    // Reset during WAIT, then a late data_rdy.
    reset_dut();
    slot_req = 4'b0100;
    xact(22'h101234, 4'b0100, 32'hCAFE0002, 1'b0);
    slot_req = '0;
    tick();
    slot_req = 4'b0010;
    tick();
    check("rw_addr", 32'(sdram_addr), 32'h000122);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_req", 32'(sdram_req), 0);
    check("rw_addr0", 32'(sdram_addr), 0);
    check("rw_ok", 32'(slot_ok), 0);
    check("rw_data", data_out, 0);
    tick();
    rst_n     = 1'b1;
    slot_req  = '0;
    data_rdy  = 1'b1;
    data_read = 32'hFEEDFACE;
    tick();
    data_rdy = 1'b0;
    check("rw_late_ok", 32'(slot_ok), 0);
    check("rw_late_data", data_out, 0);
    check("rw_late_req", 32'(sdram_req), 0);
    slot_req = 4'b1111;
    tick();
    check("rw_ptr0", 32'(sdram_addr), 32'h000011);
    slot_req = '0;
    xact(22'h000011, 4'b0001, 32'h0F0F0F0F, 1'b0);
    tick();

    // Slot 0 drops req after grant; read still completes.
    reset_dut();
    slot_req = 4'b0001;
    tick();
    check("drop_req", 32'(sdram_req), 1);
    slot_req = '0;
    xact(22'h000011, 4'b0001, 32'h77778888, 1'b0);
    tick();
    check("drop_okclr", 32'(slot_ok), 0);
    check("drop_noreq", 32'(sdram_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
